// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared RV32I decode types: ALU instruction-class encodings, writeback select
// and the ID/EX control bundle. Also used by the EX/MEM register.
package id_ex_pipeline_reg_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_R_TYPE     = 3'd0,
        ALU_I_TYPE     = 3'd1,
        ALU_BRANCH     = 3'd2,
        ALU_LOAD_STORE = 3'd3,
        ALU_LUI        = 3'd4,
        ALU_AUIPC      = 3'd5,
        ALU_JAL        = 3'd6,
        ALU_JALR       = 3'd7
    } alu_control_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } mem_to_reg_e;

    typedef struct packed {
        alu_control_e alu_control;
        logic [2:0]   func3;
        logic [6:0]   func7;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         alu_src;
        logic         branch;
        logic         jump;
        mem_to_reg_e  mem_to_reg;
    } id_ex_ctrl_t;

    // A bubble must not write, touch memory or redirect; ALU class is the address-add one.
    function automatic id_ex_ctrl_t bubble_ctrl();
        id_ex_ctrl_t c;
        c             = '0;
        c.alu_control = ALU_LOAD_STORE;
        c.mem_to_reg  = WB_ALU;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// Decode-to-Execute bundle plus pipeline control between Decode and the ID/EX register.
interface id_ex_pipeline_reg_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    import id_ex_pipeline_reg_pkg::*;

    logic [XLEN-1:0]       idPc, idRs1Data, idRs2Data, idImm;
    logic [REG_ADDR_W-1:0] idRs1Addr, idRs2Addr, idRdAddr;
    logic                  idUsesRs1, idUsesRs2;
    logic [2:0]            idFunc3;
    logic [6:0]            idFunc7;
    logic [2:0]            idAluControl;
    logic                  idRegWrite, idMemRead, idMemWrite, idAluSrc, idBranch, idJump;
    logic [1:0]            idMemToReg;
    logic                  idValid;
    logic                  holdIn, flushIn;

    logic [XLEN-1:0]       exPc, exRs1Data, exRs2Data, exImm;
    logic [REG_ADDR_W-1:0] exRs1Addr, exRs2Addr, exRdAddr;
    logic [2:0]            exFunc3;
    logic [6:0]            exFunc7;
    logic [2:0]            exAluControl;
    logic                  exRegWrite, exMemRead, exMemWrite, exAluSrc, exBranch, exJump;
    logic [1:0]            exMemToReg;
    logic                  exValid;
    logic                  stallOut;
    logic [CNT_W-1:0]      loadUseCount, flushCount;

    modport master (
        output idPc, idRs1Data, idRs2Data, idImm, idRs1Addr, idRs2Addr, idRdAddr,
               idUsesRs1, idUsesRs2, idFunc3, idFunc7, idAluControl,
               idRegWrite, idMemRead, idMemWrite, idAluSrc, idBranch, idJump,
               idMemToReg, idValid, holdIn, flushIn,
        input  exPc, exRs1Data, exRs2Data, exImm, exRs1Addr, exRs2Addr, exRdAddr,
               exFunc3, exFunc7, exAluControl,
               exRegWrite, exMemRead, exMemWrite, exAluSrc, exBranch, exJump,
               exMemToReg, exValid, stallOut, loadUseCount, flushCount
    );

    modport slave (
        input  idPc, idRs1Data, idRs2Data, idImm, idRs1Addr, idRs2Addr, idRdAddr,
               idUsesRs1, idUsesRs2, idFunc3, idFunc7, idAluControl,
               idRegWrite, idMemRead, idMemWrite, idAluSrc, idBranch, idJump,
               idMemToReg, idValid, holdIn, flushIn,
        output exPc, exRs1Data, exRs2Data, exImm, exRs1Addr, exRs2Addr, exRdAddr,
               exFunc3, exFunc7, exAluControl,
               exRegWrite, exMemRead, exMemWrite, exAluSrc, exBranch, exJump,
               exMemToReg, exValid, stallOut, loadUseCount, flushCount
    );

endinterface

// File: rtl/id_ex_pipeline_reg_load_use_detect.sv
// Flags a Decode instruction that reads the destination of a load currently in EX.
module id_ex_pipeline_reg_load_use_detect
    import id_ex_pipeline_reg_pkg::*;
(
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
    input  logic                  i_id_valid,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
    output logic                  o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is never really written, so a load to x0 cannot create a dependency.
    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
    assign o_load_use = i_ex_valid && i_ex_mem_read && (i_ex_rd_addr != '0)
                        && (w_rs1_hit || w_rs2_hit) && i_id_valid;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use stall, flush/bubble insertion and
// saturating bubble counters for performance debug.
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    id_ex_pipeline_reg_if.slave  bus
);

    logic [XLEN-1:0]       r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [REG_ADDR_W-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
    id_ex_ctrl_t           r_ctrl;
    logic                  r_valid;
    logic [CNT_W-1:0]      r_load_use_cnt, r_flush_cnt;

    logic                  w_load_use;
    id_ex_ctrl_t           w_id_ctrl;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    id_ex_pipeline_reg_load_use_detect u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd_addr  (r_rd_addr),
        .i_id_valid    (bus.idValid),
        .i_id_uses_rs1 (bus.idUsesRs1),
        .i_id_uses_rs2 (bus.idUsesRs2),
        .i_id_rs1_addr (bus.idRs1Addr),
        .i_id_rs2_addr (bus.idRs2Addr),
        .o_load_use    (w_load_use)
    );

    // Hold dominates; a flush kills the wrong-path instruction so it cannot stall.
    assign bus.stallOut = bus.holdIn || (w_load_use && !bus.flushIn);

    // Invalid Decode slots keep their fields but lose every side-effecting control.
    always_comb begin
        w_id_ctrl             = '0;
        w_id_ctrl.alu_control = alu_control_e'(bus.idAluControl);
        w_id_ctrl.func3       = bus.idFunc3;
        w_id_ctrl.func7       = bus.idFunc7;
        w_id_ctrl.alu_src     = bus.idAluSrc;
        w_id_ctrl.mem_to_reg  = mem_to_reg_e'(bus.idMemToReg);
        w_id_ctrl.reg_write   = bus.idRegWrite && bus.idValid;
        w_id_ctrl.mem_read    = bus.idMemRead  && bus.idValid;
        w_id_ctrl.mem_write   = bus.idMemWrite && bus.idValid;
        w_id_ctrl.branch      = bus.idBranch   && bus.idValid;
        w_id_ctrl.jump        = bus.idJump     && bus.idValid;
    end

    // Priority: hold > flush > load-use > normal advance.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pc           <= '0;
            r_rs1_data     <= '0;
            r_rs2_data     <= '0;
            r_imm          <= '0;
            r_rs1_addr     <= '0;
            r_rs2_addr     <= '0;
            r_rd_addr      <= '0;
            r_ctrl         <= bubble_ctrl();
            r_valid        <= 1'b0;
            r_load_use_cnt <= '0;
            r_flush_cnt    <= '0;
        end else if (!bus.holdIn) begin
            r_pc       <= bus.idPc;
            r_rs1_data <= bus.idRs1Data;
            r_rs2_data <= bus.idRs2Data;
            r_imm      <= bus.idImm;
            r_rs1_addr <= bus.idRs1Addr;
            r_rs2_addr <= bus.idRs2Addr;
            if (bus.flushIn || w_load_use) begin
                r_ctrl    <= bubble_ctrl();
                r_rd_addr <= '0;
                r_valid   <= 1'b0;
            end else begin
                r_ctrl    <= w_id_ctrl;
                r_rd_addr <= bus.idRdAddr;
                r_valid   <= bus.idValid;
            end
            if (bus.flushIn) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end else if (w_load_use) begin
                r_load_use_cnt <= sat_inc(r_load_use_cnt);
            end
        end
    end

    assign bus.exPc         = r_pc;
    assign bus.exRs1Data    = r_rs1_data;
    assign bus.exRs2Data    = r_rs2_data;
    assign bus.exImm        = r_imm;
    assign bus.exRs1Addr    = r_rs1_addr;
    assign bus.exRs2Addr    = r_rs2_addr;
    assign bus.exRdAddr     = r_rd_addr;
    assign bus.exFunc3      = r_ctrl.func3;
    assign bus.exFunc7      = r_ctrl.func7;
    assign bus.exAluControl = 3'(r_ctrl.alu_control);
    assign bus.exRegWrite   = r_ctrl.reg_write;
    assign bus.exMemRead    = r_ctrl.mem_read;
    assign bus.exMemWrite   = r_ctrl.mem_write;
    assign bus.exAluSrc     = r_ctrl.alu_src;
    assign bus.exBranch     = r_ctrl.branch;
    assign bus.exJump       = r_ctrl.jump;
    assign bus.exMemToReg   = 2'(r_ctrl.mem_to_reg);
    assign bus.exValid      = r_valid;
    assign bus.loadUseCount = r_load_use_cnt;
    assign bus.flushCount   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for the ID/EX register: directed instruction vectors, expected
// EX bundle, stall and counters queued by the driver and checked by a monitor.
module tb_id_ex_pipeline_reg;

    localparam int K_LOAD = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        us1, us2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  alu;
        logic        rw, mr, mw, as, br, jp;
        logic [1:0]  m2r;
        logic        v;
    } instr_t;

    typedef struct {
        instr_t ex;
        bit     bubble;
        bit     stall;
        int     lu;
        int     fl;
    } exp_t;

    logic   clk = 1'b0;
    logic   rstN;
    int     checks = 0;
    int     errors = 0;
    exp_t   q[$];
    instr_t last_ex;
    bit     last_bub;

    id_ex_pipeline_reg_if #(.XLEN(32), .CNT_W(4)) bus();

    id_ex_pipeline_reg #(.XLEN(32), .CNT_W(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t base(input logic [31:0] pc);
        instr_t i;
        i      = '0;
        i.pc   = pc;
        i.rs1d = {pc[15:0], 16'hA5A5};
        i.rs2d = ~pc;
        i.imm  = pc + 32'h40;
        i.v    = 1'b1;
        return i;
    endfunction

    function automatic instr_t add(input logic [31:0] pc, input logic [4:0] rd, rs1, rs2);
        instr_t i;
        i = base(pc);
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.us1 = 1'b1; i.us2 = 1'b1;
        i.alu = 3'd0; i.rw = 1'b1; i.m2r = 2'd0;
        return i;
    endfunction

    function automatic instr_t lw(input logic [31:0] pc, input logic [4:0] rd, rs1);
        instr_t i;
        i = base(pc);
        i.rd = rd; i.rs1 = rs1; i.us1 = 1'b1;
        i.alu = 3'd3; i.f3 = 3'd2; i.rw = 1'b1; i.mr = 1'b1; i.as = 1'b1; i.m2r = 2'd1;
        return i;
    endfunction

    function automatic instr_t lui(input logic [31:0] pc, input logic [4:0] rd);
        instr_t i;
        i = base(pc);
        i.rd = rd; i.rs1 = rd; i.rs2 = rd;
        i.alu = 3'd4; i.rw = 1'b1; i.as = 1'b1; i.m2r = 2'd0;
        return i;
    endfunction

    function automatic instr_t jal(input logic [31:0] pc, input logic [4:0] rd);
        instr_t i;
        i = base(pc);
        i.rd = rd; i.alu = 3'd6; i.rw = 1'b1; i.jp = 1'b1; i.m2r = 2'd2;
        return i;
    endfunction

    task automatic drive(input instr_t id, input bit hold, input bit flush);
        bus.idPc = id.pc; bus.idRs1Data = id.rs1d; bus.idRs2Data = id.rs2d; bus.idImm = id.imm;
        bus.idRs1Addr = id.rs1; bus.idRs2Addr = id.rs2; bus.idRdAddr = id.rd;
        bus.idUsesRs1 = id.us1; bus.idUsesRs2 = id.us2;
        bus.idFunc3 = id.f3; bus.idFunc7 = id.f7; bus.idAluControl = id.alu;
        bus.idRegWrite = id.rw; bus.idMemRead = id.mr; bus.idMemWrite = id.mw;
        bus.idAluSrc = id.as; bus.idBranch = id.br; bus.idJump = id.jp;
        bus.idMemToReg = id.m2r; bus.idValid = id.v;
        bus.holdIn = hold; bus.flushIn = flush;
    endtask

    task automatic step(input instr_t id, input bit hold, input bit flush, input bit e_stall,
                        input int kind, input int e_lu, input int e_fl);
        exp_t e;
        @(negedge clk);
        drive(id, hold, flush);
        e.ex = id;
        e.bubble = 1'b0;
        if (kind == K_LOAD && !id.v) begin
            e.ex.rw = 1'b0; e.ex.mr = 1'b0; e.ex.mw = 1'b0; e.ex.br = 1'b0; e.ex.jp = 1'b0;
        end
        if (kind == K_BUB)  e.bubble = 1'b1;
        if (kind == K_HOLD) begin e.ex = last_ex; e.bubble = last_bub; end
        last_ex  = e.ex;
        last_bub = e.bubble;
        e.stall = e_stall; e.lu = e_lu; e.fl = e_fl;
        q.push_back(e);
    endtask

    // Monitor: stall sampled just before the edge, registered outputs just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stallOut", 32'(bus.stallOut), 32'(e.stall));
                @(posedge clk);
                #1;
                chk("loadUseCount", 32'(bus.loadUseCount), 32'(e.lu));
                chk("flushCount", 32'(bus.flushCount), 32'(e.fl));
                if (e.bubble) begin
                    chk("bubble exValid", 32'(bus.exValid), 32'd0);
                    chk("bubble exRdAddr", 32'(bus.exRdAddr), 32'd0);
                    chk("bubble ctrl", {27'd0, bus.exRegWrite, bus.exMemRead, bus.exMemWrite,
                                        bus.exBranch, bus.exJump}, 32'd0);
                    chk("bubble exMemToReg", 32'(bus.exMemToReg), 32'd0);
                    chk("bubble exAluControl", 32'(bus.exAluControl), 32'd3);
                end else begin
                    chk("exValid", 32'(bus.exValid), 32'(e.ex.v));
                    chk("exRdAddr", 32'(bus.exRdAddr), 32'(e.ex.rd));
                    chk("exRegWrite", 32'(bus.exRegWrite), 32'(e.ex.rw));
                    chk("exMemRead", 32'(bus.exMemRead), 32'(e.ex.mr));
                    chk("exMemWrite", 32'(bus.exMemWrite), 32'(e.ex.mw));
                    chk("exBranch", 32'(bus.exBranch), 32'(e.ex.br));
                    chk("exJump", 32'(bus.exJump), 32'(e.ex.jp));
                    chk("exAluControl", 32'(bus.exAluControl), 32'(e.ex.alu));
                    chk("exAluSrc", 32'(bus.exAluSrc), 32'(e.ex.as));
                    chk("exPc", bus.exPc, e.ex.pc);
                    chk("exRs1Data", bus.exRs1Data, e.ex.rs1d);
                    chk("exRs2Data", bus.exRs2Data, e.ex.rs2d);
                    chk("exImm", bus.exImm, e.ex.imm);
                    chk("exRs1Addr", 32'(bus.exRs1Addr), 32'(e.ex.rs1));
                    chk("exRs2Addr", 32'(bus.exRs2Addr), 32'(e.ex.rs2));
                    chk("exFunc3", 32'(bus.exFunc3), 32'(e.ex.f3));
                    chk("exFunc7", 32'(bus.exFunc7), 32'(e.ex.f7));
                    if (e.ex.v) chk("exMemToReg", 32'(bus.exMemToReg), 32'(e.ex.m2r));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t inv;
        rstN = 1'b1;
        drive('0, 1'b0, 1'b0);
        #1 rstN = 1'b0;
        #2;
        chk("reset exValid", 32'(bus.exValid), 32'd0);
        chk("reset exAluControl", 32'(bus.exAluControl), 32'd3);
        chk("reset exRdAddr", 32'(bus.exRdAddr), 32'd0);
        chk("reset exPc", bus.exPc, 32'd0);
        chk("reset counters", {bus.loadUseCount, bus.flushCount}, 32'd0);
        chk("reset stallOut", 32'(bus.stallOut), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        //   instruction                   hold flush stall kind    lu fl
        step(add(32'h100, 5'd3, 5'd1, 5'd2), 0, 0, 0, K_LOAD, 0, 0);
        step(lw (32'h104, 5'd5, 5'd1),       0, 0, 0, K_LOAD, 0, 0);
        step(add(32'h108, 5'd6, 5'd5, 5'd1), 0, 0, 1, K_BUB,  1, 0);
        step(add(32'h108, 5'd6, 5'd5, 5'd1), 0, 0, 0, K_LOAD, 1, 0);
        step(lw (32'h10C, 5'd0, 5'd2),       0, 0, 0, K_LOAD, 1, 0);
        step(add(32'h110, 5'd7, 5'd0, 5'd0), 0, 0, 0, K_LOAD, 1, 0);
        step(lw (32'h114, 5'd5, 5'd2),       0, 0, 0, K_LOAD, 1, 0);
        step(lui(32'h118, 5'd5),             0, 0, 0, K_LOAD, 1, 0);
        step(lw (32'h11C, 5'd5, 5'd2),       0, 0, 0, K_LOAD, 1, 0);
        inv = add(32'h120, 5'd8, 5'd1, 5'd5);
        inv.v = 1'b0; inv.mw = 1'b1; inv.br = 1'b1;
        step(inv,                            0, 0, 0, K_LOAD, 1, 0);
        step(lw (32'h124, 5'd5, 5'd2),       0, 0, 0, K_LOAD, 1, 0);
        step(add(32'h128, 5'd9, 5'd5, 5'd5), 0, 1, 0, K_BUB,  1, 1);
        step(lw (32'h12C, 5'd5, 5'd3),       0, 0, 0, K_LOAD, 1, 1);
        step(add(32'h130, 5'd6, 5'd5, 5'd1), 1, 0, 1, K_HOLD, 1, 1);
        step(add(32'h130, 5'd6, 5'd5, 5'd1), 1, 1, 1, K_HOLD, 1, 1);
        step(add(32'h130, 5'd6, 5'd5, 5'd1), 1, 1, 1, K_HOLD, 1, 1);
        step(add(32'h130, 5'd6, 5'd5, 5'd1), 1, 1, 1, K_HOLD, 1, 1);
        step(add(32'h130, 5'd6, 5'd5, 5'd1), 0, 0, 1, K_BUB,  2, 1);
        step(add(32'h130, 5'd6, 5'd5, 5'd1), 0, 0, 0, K_LOAD, 2, 1);
        step(jal(32'h134, 5'd1),             0, 0, 0, K_LOAD, 2, 1);

        for (int k = 1; k <= 20; k++)
            step(add(32'h200 + 32'(k * 4), 5'd9, 5'd5, 5'd5), 0, 1, 0, K_BUB, 2,
                 (1 + k > 15) ? 15 : 1 + k);

        // Reset arriving mid-cycle while a load-use stall is in progress.
        step(lw(32'h300, 5'd5, 5'd1), 0, 0, 0, K_LOAD, 2, 15);
        @(negedge clk);
        drive(add(32'h304, 5'd6, 5'd5, 5'd1), 1'b0, 1'b0);
        #1;
        chk("pre-reset stallOut", 32'(bus.stallOut), 32'd1);
        #1 rstN = 1'b0;
        #1;
        chk("async exValid", 32'(bus.exValid), 32'd0);
        chk("async exRdAddr", 32'(bus.exRdAddr), 32'd0);
        chk("async exMemRead", 32'(bus.exMemRead), 32'd0);
        chk("async exRegWrite", 32'(bus.exRegWrite), 32'd0);
        chk("async exAluControl", 32'(bus.exAluControl), 32'd3);
        chk("async loadUseCount", 32'(bus.loadUseCount), 32'd0);
        chk("async flushCount", 32'(bus.flushCount), 32'd0);
        chk("async stallOut", 32'(bus.stallOut), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        step(add(32'h308, 5'd3, 5'd1, 5'd2), 0, 0, 0, K_LOAD, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
